// File: rtl/csah_sub64_pipe_if.sv
// Handshake/data bundle for csah_sub64_pipe: operand side (in_*) and result side (out_*).
// With SUB_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface csah_sub64_pipe_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout
    );
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout
    );
`endif
endinterface

// File: rtl/csah_sub64_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin, split at bit M, valid/ready on both sides.
// Optional macro SUB_OVF_EN adds a registered two's-complement overflow flag (bus.ovf).
module csah_sub64_pipe #(
    parameter int N = 64,
    parameter int M = 32
) (
    input logic              clk,
    input logic              rst_n,
    csah_sub64_pipe_if.slave bus
);
    localparam int H  = N - M;
    localparam int L0 = M / 2;
    localparam int L1 = M - L0;
    localparam int H0 = H / 2;
    localparam int H1 = H - H0;

    // Stage 1: low half a + ~b + ~bin, carry-select split at L0.
    logic [M-1:0] a_lo;
    logic [M-1:0] bn_lo;
    logic         cin_lo;
    logic [L0:0]  lo_p0;
    logic [L1:0]  lo_u0;
    logic [L1:0]  lo_u1;
    logic [L1:0]  lo_sel;
    logic [M-1:0] d_lo;
    logic         b1;

    assign a_lo   = bus.a[M-1:0];
    assign bn_lo  = ~bus.b[M-1:0];
    assign cin_lo = ~bus.bin;
    assign lo_p0  = {1'b0, a_lo[L0-1:0]} + {1'b0, bn_lo[L0-1:0]} + {{L0{1'b0}}, cin_lo};
    assign lo_u0  = {1'b0, a_lo[M-1:L0]} + {1'b0, bn_lo[M-1:L0]};
    assign lo_u1  = {1'b0, a_lo[M-1:L0]} + {1'b0, bn_lo[M-1:L0]} + {{L1{1'b0}}, 1'b1};
    assign lo_sel = lo_p0[L0] ? lo_u1 : lo_u0;
    assign d_lo   = {lo_sel[L1-1:0], lo_p0[L0-1:0]};
    assign b1     = ~lo_sel[L1];

    logic         s1_valid_q, s1_valid_d;
    logic [M-1:0] s1_d_lo_q,  s1_d_lo_d;
    logic         s1_b1_q,    s1_b1_d;
    logic [H-1:0] s1_a_hi_q,  s1_a_hi_d;
    logic [H-1:0] s1_b_hi_q,  s1_b_hi_d;
`ifdef SUB_OVF_EN
    logic         s1_sa_q,    s1_sa_d;
    logic         s1_sb_q,    s1_sb_d;
`endif

    // Stage 2: high half on the registered operands, carry-in is the registered low carry.
    logic [H-1:0] bn_hi;
    logic         cin_hi;
    logic [H0:0]  hi_p0;
    logic [H1:0]  hi_u0;
    logic [H1:0]  hi_u1;
    logic [H1:0]  hi_sel;
    logic [N-1:0] d_full;
    logic         bout_full;

    assign bn_hi     = ~s1_b_hi_q;
    assign cin_hi    = ~s1_b1_q;
    assign hi_p0     = {1'b0, s1_a_hi_q[H0-1:0]} + {1'b0, bn_hi[H0-1:0]} + {{H0{1'b0}}, cin_hi};
    assign hi_u0     = {1'b0, s1_a_hi_q[H-1:H0]} + {1'b0, bn_hi[H-1:H0]};
    assign hi_u1     = {1'b0, s1_a_hi_q[H-1:H0]} + {1'b0, bn_hi[H-1:H0]} + {{H1{1'b0}}, 1'b1};
    assign hi_sel    = hi_p0[H0] ? hi_u1 : hi_u0;
    assign d_full    = {hi_sel[H1-1:0], hi_p0[H0-1:0], s1_d_lo_q};
    assign bout_full = ~hi_sel[H1];

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] d_q,         d_d;
    logic         bout_q,      bout_d;
`ifdef SUB_OVF_EN
    logic         ovf_q,       ovf_d;
`endif

    logic adv1;
    logic adv2;
    logic accept;

    assign adv2   = !out_valid_q | bus.out_ready;
    assign adv1   = !s1_valid_q | adv2;
    assign accept = bus.in_valid & adv1;

    always_comb begin
        // NOTE: every next-state variable defaults to its held value first, so no path infers a latch.
        s1_valid_d  = s1_valid_q;
        s1_d_lo_d   = s1_d_lo_q;
        s1_b1_d     = s1_b1_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
`ifdef SUB_OVF_EN
        s1_sa_d     = s1_sa_q;
        s1_sb_d     = s1_sb_q;
        ovf_d       = ovf_q;
`endif
        out_valid_d = out_valid_q;
        d_d         = d_q;
        bout_d      = bout_q;

        if (adv1) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d_lo_d = d_lo;
                s1_b1_d   = b1;
                s1_a_hi_d = bus.a[N-1:M];
                s1_b_hi_d = bus.b[N-1:M];
`ifdef SUB_OVF_EN
                s1_sa_d   = bus.a[N-1];
                s1_sb_d   = bus.b[N-1];
`endif
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d    = d_full;
                bout_d = bout_full;
`ifdef SUB_OVF_EN
                ovf_d  = (s1_sa_q != s1_sb_q) & (d_full[N-1] != s1_sa_q);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared as well as valids, so d/bout read 0 after reset.
            s1_valid_q  <= 1'b0;
            s1_d_lo_q   <= '0;
            s1_b1_q     <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
`ifdef SUB_OVF_EN
            s1_sa_q     <= 1'b0;
            s1_sb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make both stages sample pre-edge values, so the pipe shifts cleanly.
            s1_valid_q  <= s1_valid_d;
            s1_d_lo_q   <= s1_d_lo_d;
            s1_b1_q     <= s1_b1_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
`ifdef SUB_OVF_EN
            s1_sa_q     <= s1_sa_d;
            s1_sb_q     <= s1_sb_d;
            ovf_q       <= ovf_d;
`endif
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
`ifdef SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_csah_sub64_pipe.sv
// Self-checking bench for csah_sub64_pipe: directed vectors, streaming, backpressure, reset mid-stream.
// Define SUB_OVF_EN for both bench and RTL to check the overflow flag.
module tb_csah_sub64_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    csah_sub64_pipe_if #(.N(64)) bus ();

    csah_sub64_pipe #(.N(64), .M(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        exp_t       e;
        logic [64:0] r;
        r      = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        e.d    = r[63:0];
        e.bout = r[64];
        e.ovf  = (a[63] != b[63]) && (r[63] != a[63]);
        return e;
    endfunction

    // Scoreboard one cycle: score a consumed result, record an accepted operand, then advance.
    task automatic step();
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_d", bus.d, e.d);
                check("sb_bout", {63'd0, bus.bout}, {63'd0, e.bout});
`ifdef SUB_OVF_EN
                check("sb_ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
`endif
            end
        end
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a, bus.b, bus.bin));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic bin, input logic [63:0] ed, input logic eb, input logic eo);
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        check({tag, "_valid_t1"}, {63'd0, bus.out_valid}, 64'd0);
        step();
        check({tag, "_valid_t2"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, "_d"}, bus.d, ed);
        check({tag, "_bout"}, {63'd0, bus.bout}, {63'd0, eb});
`ifdef SUB_OVF_EN
        check({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, eo});
`endif
        step();
    endtask

    task automatic drain(input int budget);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() > 0; i++)
            step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] bp_a[5];
        logic [63:0] bp_b[5];
        int          n_acc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_d", bus.d, 64'd0);
        check("rst_bout", {63'd0, bus.bout}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef SUB_OVF_EN
        check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
`endif

        // Directed vectors with hand-computed results.
        run_one("xhalf", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        run_one("wrap", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_one("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_one("lo_borrow", 64'h0123_4567_89AB_CDEF, 64'h0000_0000_89AB_CDF0, 1'b0,
                64'h0123_4566_FFFF_FFFF, 1'b0, 1'b0);
        run_one("sovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

        // Streaming: continuous input with the consumer always ready.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.a   = {$urandom, $urandom};
            bus.b   = (i % 10 == 3) ? bus.a : {$urandom, $urandom};
            bus.bin = 1'($urandom_range(0, 1));
            check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
            if (i >= 2)
                check("stream_out_valid", {63'd0, bus.out_valid}, 64'd1);
            step();
        end
        drain(8);

        // Backpressure: consumer stalled for 5 cycles while operands are offered.
        bp_a[0] = 64'd100; bp_b[0] = 64'd30;
        bp_a[1] = 64'd5;   bp_b[1] = 64'd7;
        bp_a[2] = 64'd900; bp_b[2] = 64'd1;
        bp_a[3] = 64'd901; bp_b[3] = 64'd2;
        bp_a[4] = 64'd902; bp_b[4] = 64'd3;
        n_acc         = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.bin       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.a = bp_a[i];
            bus.b = bp_b[i];
            if (i >= 2) begin
                check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
                check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
                check("bp_d_stable", bus.d, 64'd70);
                check("bp_bout_stable", {63'd0, bus.bout}, 64'd0);
            end
            if (bus.in_valid && bus.in_ready)
                n_acc++;
            step();
        end
        check("bp_accepts", 64'(n_acc), 64'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_first_d", bus.d, 64'd70);
        step();
        check("bp_second_valid", {63'd0, bus.out_valid}, 64'd1);
        check("bp_second_d", bus.d, 64'hFFFF_FFFF_FFFF_FFFE);
        check("bp_second_bout", {63'd0, bus.bout}, 64'd1);
        step();
        check("bp_no_dup", {63'd0, bus.out_valid}, 64'd0);
        drain(4);

        // Reset with two operations in flight.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a = 64'd10; bus.b = 64'd3;
        step();
        bus.a = 64'd20; bus.b = 64'd4;
        step();
        check("mid_pre_valid", {63'd0, bus.out_valid}, 64'd1);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_d", bus.d, 64'd0);
        check("mid_rst_bout", {63'd0, bus.bout}, 64'd0);
        check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        exp_q.delete();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_no_stale", {63'd0, bus.out_valid}, 64'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
